// File: rtl/dpsram_fifo_ctl.sv
// FIFO controller for a 2-port RAM: valid/ready push -> RAM writes, RAM reads
// prefetched into a 2-deep output/skid buffer -> valid/ready pop.
module dpsram_fifo_ctl #(
  parameter int AW = 5,
  parameter int DW = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ena_i,
  input  logic [DW-1:0] dat_i,
  input  logic          stb_i,
  output logic          ack_o,
  output logic [DW-1:0] dat_o,
  output logic          stb_o,
  input  logic          ack_i,
  output logic [AW+1:0] lvl_o,
  output logic [AW-1:0] ram_adr_o,
  output logic [DW-1:0] ram_dat_o,
  output logic          ram_wre_o,
  output logic [AW-1:0] ram_xadr_o,
  input  logic [DW-1:0] ram_xdat_i
);

  localparam logic [AW:0] L_FULL = {1'b1, {AW{1'b0}}};

  logic [AW:0]   r_wp, r_rp, r_mcnt;
  logic          r_fv, r_ov, r_sv;
  logic [DW-1:0] r_od, r_sd;

  logic          w_push, w_pop, w_fetch;
  logic [1:0]    w_b;
  logic [AW:0]   w_mcnt_nxt;

  assign ack_o  = ena_i & ~rst_i & (r_mcnt != L_FULL);
  assign w_push = stb_i & ack_o;
  assign w_pop  = r_ov & ack_i & ena_i;
  assign w_b    = {1'b0, r_fv} + {1'b0, r_ov} + {1'b0, r_sv};

  // A fetch may refill a full buffer only when a pop frees a slot in the same cycle.
  assign w_fetch = ena_i & ~rst_i & (r_mcnt != '0) &
                   ((w_b < 2'd2) | ((w_b == 2'd2) & w_pop));

  always_comb begin
    // NOTE: default first so every path assigns w_mcnt_nxt and no latch is inferred.
    w_mcnt_nxt = r_mcnt;
    if (w_push && !w_fetch)      w_mcnt_nxt = r_mcnt + 1'b1;
    else if (!w_push && w_fetch) w_mcnt_nxt = r_mcnt - 1'b1;
  end

  assign stb_o      = r_ov;
  assign dat_o      = r_od;
  assign ram_adr_o  = r_wp[AW-1:0];
  assign ram_dat_o  = dat_i;
  assign ram_wre_o  = w_push;
  assign ram_xadr_o = r_rp[AW-1:0];
  assign lvl_o      = (AW+2)'(r_mcnt) + (AW+2)'(r_fv) + (AW+2)'(r_ov) + (AW+2)'(r_sv);

  // NOTE: all state updates use non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_mcnt <= '0;
      r_fv   <= 1'b0;
      r_ov   <= 1'b0;
      r_sv   <= 1'b0;
      r_od   <= '0;
      r_sd   <= '0;
    end else if (ena_i) begin
      if (w_push)  r_wp <= r_wp + 1'b1;
      if (w_fetch) r_rp <= r_rp + 1'b1;
      r_mcnt <= w_mcnt_nxt;
      r_fv   <= w_fetch;
      if (r_fv) begin
        if (!r_ov || (w_pop && !r_sv)) begin
          r_od <= ram_xdat_i;
          r_ov <= 1'b1;
        end else if (w_pop) begin
          r_od <= r_sd;
          r_sd <= ram_xdat_i;
        end else begin
          r_sd <= ram_xdat_i;
          r_sv <= 1'b1;
        end
      end else if (w_pop) begin
        if (r_sv) begin
          r_od <= r_sd;
          r_sv <= 1'b0;
        end else begin
          r_ov <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dpsram_fifo_ctl.sv
// Scoreboard bench for dpsram_fifo_ctl (AW=2, DW=8) with a behavioural 2-port RAM.
module tb_dpsram_fifo_ctl;

  localparam int AW = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, ena, stb_in, ack_in;
  logic [DW-1:0] dat_in;
  logic          ack_out, stb_out;
  logic [DW-1:0] dat_out;
  logic [AW+1:0] lvl;
  logic [AW-1:0] ram_adr, ram_xadr;
  logic [DW-1:0] ram_wdat, ram_xdat;
  logic          ram_wre;

  always #5 clk = ~clk;

  dpsram_fifo_ctl #(.AW(AW), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst), .ena_i(ena), .dat_i(dat_in), .stb_i(stb_in),
    .ack_o(ack_out), .dat_o(dat_out), .stb_o(stb_out), .ack_i(ack_in),
    .lvl_o(lvl), .ram_adr_o(ram_adr), .ram_dat_o(ram_wdat), .ram_wre_o(ram_wre),
    .ram_xadr_o(ram_xadr), .ram_xdat_i(ram_xdat)
  );

  // RAM: registered addresses gated by the shared enable, combinational read data.
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] xadr_q;
  always @(posedge clk) begin
    if (ena) begin
      if (ram_wre) mem[ram_adr] <= ram_wdat;
      xadr_q <= ram_xadr;
    end
  end
  assign ram_xdat = mem[xadr_q];

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];
  logic mon_en = 1'b0;
  logic saw_sv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: level must equal words accepted minus words popped; pops checked in order.
  always @(negedge clk) begin
    if (mon_en) begin
      check("lvl_vs_scoreboard", 32'(lvl), 32'(exp_q.size()));
      if (rst) begin
        exp_q.delete();
      end else begin
        if (ena && stb_out && ack_in) begin
          check("pop_has_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("pop_data", 32'(dat_out), 32'(exp_q.pop_front()));
        end
        if (ena && stb_in && ack_out) exp_q.push_back(dat_in);
        if (dut.r_sv) saw_sv = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic wait_empty(input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) tick();
    mid();
    check("drain_done", 32'(exp_q.size()), 32'd0);
    check("drain_stb_low", 32'(stb_out), 32'd0);
    tick();
  endtask

  int i, c, wraps;
  logic          f_stb;
  logic [DW-1:0] f_dat;
  logic [AW+1:0] f_lvl;

  initial begin
    rst = 1'b1; ena = 1'b1; stb_in = 1'b0; ack_in = 1'b0; dat_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    mid();
    check("rst_stb", 32'(stb_out), 32'd0);
    check("rst_dat", 32'(dat_out), 32'd0);
    check("rst_lvl", 32'(lvl), 32'd0);
    tick();

    // Single word: stb_o rises three cycles after the push.
    stb_in = 1'b1; dat_in = 8'h02; ack_in = 1'b1;
    mid();
    check("t1_ack", 32'(ack_out), 32'd1);
    check("t1_wre", 32'(ram_wre), 32'd1);
    check("t1_adr", 32'(ram_adr), 32'd0);
    tick(); stb_in = 1'b0;
    mid(); check("t1_c1_stb", 32'(stb_out), 32'd0);
    tick(); mid(); check("t1_c2_stb", 32'(stb_out), 32'd0);
    tick(); mid(); check("t1_c3_stb", 32'(stb_out), 32'd1);
    check("t1_c3_dat", 32'(dat_out), 32'h02);
    tick(); mid(); check("t1_c4_lvl", 32'(lvl), 32'd0);
    check("t1_c4_stb", 32'(stb_out), 32'd0);
    tick();

    // Fill with no pops: six accepted, seventh refused.
    ack_in = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      stb_in = 1'b1; dat_in = DW'(k);
      mid();
      check("t2_fill_ack", 32'(ack_out), (k <= 6) ? 32'd1 : 32'd0);
      tick();
    end
    stb_in = 1'b0;
    mid();
    check("t2_full_lvl", 32'(lvl), 32'd6);
    check("t2_head", 32'(dat_out), 32'd1);
    tick();
    ack_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      mid(); check("t2_drain_stb", 32'(stb_out), 32'd1);
      tick();
    end
    wait_empty(4);

    // Streaming: 20 back-to-back pushes, pops continuous from cycle 3 to 22.
    wraps = 0;
    for (int k = 0; k < 23; k++) begin
      stb_in = (k < 20); dat_in = DW'(8'h10 + k);
      mid();
      if (ram_wre && ram_adr == 2'd3) wraps++;
      if (k >= 3) check("t3_stream_stb", 32'(stb_out), 32'd1);
      tick();
    end
    stb_in = 1'b0;
    check("t3_wraps_ge4", 32'(wraps >= 4), 32'd1);
    wait_empty(4);

    // Backpressure: ack_i pattern 1,0,0,1 with continuous push attempts.
    i = 0; c = 0;
    while (i < 12 && c < 200) begin
      stb_in = 1'b1; dat_in = DW'(8'h20 + i);
      ack_in = (c % 4 == 0) || (c % 4 == 3);
      mid();
      if (ack_out) i++;
      tick(); c++;
    end
    stb_in = 1'b0; ack_in = 1'b1;
    check("t4_all_pushed", 32'(i), 32'd12);
    wait_empty(20);
    check("t4_skid_used", 32'(saw_sv), 32'd1);

    // Enable stall in cycles 4..6 of a stream.
    i = 0; ack_in = 1'b1;
    for (c = 0; c < 16; c++) begin
      ena = !(c >= 4 && c < 7);
      stb_in = (i < 10); dat_in = DW'(8'h40 + i);
      mid();
      if (!ena) begin
        check("t5_stall_ack", 32'(ack_out), 32'd0);
        check("t5_stall_wre", 32'(ram_wre), 32'd0);
      end
      if (c == 4) begin
        f_stb = stb_out; f_dat = dat_out; f_lvl = lvl;
      end else if (c >= 5 && c <= 7) begin
        check("t5_frozen_stb", 32'(stb_out), 32'(f_stb));
        check("t5_frozen_dat", 32'(dat_out), 32'(f_dat));
        check("t5_frozen_lvl", 32'(lvl), 32'(f_lvl));
      end
      if (ena && stb_in && ack_out) i++;
      tick();
    end
    ena = 1'b1; stb_in = 1'b0;
    check("t5_all_pushed", 32'(i), 32'd10);
    wait_empty(10);

    // Reset with four words held, then a fresh push lands at address 0.
    ack_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      stb_in = 1'b1; dat_in = DW'(8'hA0 + k);
      tick();
    end
    stb_in = 1'b0;
    mid(); check("t6_pre_lvl", 32'(lvl), 32'd4);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; stb_in = 1'b1; dat_in = 8'h01; ack_in = 1'b1;
    mid();
    check("t6_post_stb", 32'(stb_out), 32'd0);
    check("t6_post_dat", 32'(dat_out), 32'd0);
    check("t6_post_lvl", 32'(lvl), 32'd0);
    check("t6_first_adr", 32'(ram_adr), 32'd0);
    check("t6_first_wre", 32'(ram_wre), 32'd1);
    tick(); stb_in = 1'b0;
    mid(); check("t6_c1_stb", 32'(stb_out), 32'd0);
    tick(); mid(); check("t6_c2_stb", 32'(stb_out), 32'd0);
    tick(); mid(); check("t6_c3_stb", 32'(stb_out), 32'd1);
    check("t6_c3_dat", 32'(dat_out), 32'h01);
    tick();
    wait_empty(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
